baud_rate_gen_frac: RTL and testbench
=====================================

BAUD_RATE_GEN_FRAC -- requirements
Module: baud_rate_gen_frac

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning reset-time baud rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning oversample ticks per bit; even, >=2.
REQ-004 SHALL have parameter ACC_W, default 24, meaning phase accumulator fraction width in bits.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port enable, input, 1, meaning advance the accumulator when high.
REQ-008 SHALL have port resync, input, 1, meaning realign phase to mid-bit (start-bit edge).
REQ-009 SHALL have port inc_in, input, ACC_W, meaning new phase increment value.
REQ-010 SHALL have port inc_load, input, 1, meaning capture inc_in into the shadow register.
REQ-011 SHALL have port os_tick, output, 1, meaning one-cycle pulse at BAUD*OVERSAMPLE rate.
REQ-012 SHALL have port baud_tick, output, 1, meaning one-cycle pulse at bit rate.
REQ-013 SHALL have port inc_pending, output, 1, meaning the shadow increment is not yet applied.

Function
REQ-014 SHALL compute DEF_INC = round(BAUD*OVERSAMPLE*2^ACC_W / CLK_FREQ), saturated to 2^ACC_W-1.
REQ-015 SHALL, on each enabled edge, form the ACC_W+1-bit sum acc+inc; acc takes the low ACC_W bits; the carry bit registers into os_tick.
REQ-016 SHALL, when enable is low, hold acc and the subcounter and drive os_tick=0 and baud_tick=0.
REQ-017 SHALL increment a subcounter (0..OVERSAMPLE-1) on each carry, wrapping OVERSAMPLE-1->0.
REQ-018 SHALL assert baud_tick in the same cycle as the os_tick whose carry occurred with subcounter==OVERSAMPLE-1.
REQ-019 SHALL, on resync high at an edge, load acc=0 and subcounter=OVERSAMPLE/2 and drive os_tick=0 and baud_tick=0 next cycle, regardless of enable.
REQ-020 SHALL give resync priority over accumulation in the same edge.
REQ-021 SHALL, on inc_load, capture inc_in into the shadow register and set inc_pending; a later load before application overwrites it (last wins).
REQ-022 SHALL copy the shadow into the active increment, and clear inc_pending, at the first edge where inc_pending=1 and (carry occurs or enable=0 or resync=1).
REQ-023 SHALL use the old increment for the sum in the edge where the swap happens.
REQ-024 SHALL, when inc_load and the apply condition coincide, apply the older shadow and keep inc_pending set with the new value.
REQ-025 SHALL, when the active increment is 0, never produce ticks.
REQ-026 SHALL have ticks that are never high for more than one consecutive cycle unless the increment is >=2^(ACC_W-1).

Reset
REQ-027 SHALL, when rst is asserted, asynchronously set acc=0, subcounter=0, active and shadow increment=DEF_INC, inc_pending=0, os_tick=0 and baud_tick=0.
REQ-028 SHALL resume accumulation at the first enabled edge after rst deasserts; rst mid-load discards the pending shadow.

Structure
REQ-029 SHALL keep a shared package baud_pkg holding the clog2 function and the DEF_INC computation function.
REQ-030 SHALL instantiate one sub-module, phase_acc, which contains the accumulator, the increment, the shadow register and the os_tick carry; the top holds the subcounter and baud_tick.
REQ-031 SHALL size the subcounter as clog2(OVERSAMPLE) bits.

Verification (ACC_W=8, OVERSAMPLE=4, inc_load 64 then reset-free run)
REQ-032 SHALL cover: rst, then load 64 with enable=0 (applies next edge), then enable=1 -> os_tick every 4th cycle; baud_tick on 4th os_tick (cycle 16), then every 16.
REQ-033 SHALL cover: resync mid-run -> os_tick 4 cycles after resync and baud_tick 8 cycles after resync.
REQ-034 SHALL cover: inc_load 128 mid-interval -> inc_pending high until next os_tick, then os_tick every 2 cycles and baud_tick every 8 cycles.
REQ-035 SHALL cover: enable low for 5 cycles mid-interval -> no ticks; the remaining phase resumes exactly (tick cycle count shifts by 5).
REQ-036 SHALL cover: inc 0 -> no ticks over 1000 cycles; default params -> 1000 baud_ticks within +-0.1% of 434027 cycles.
REQ-037 SHALL cover: rst asserted between clock edges during inc_pending -> all outputs 0 immediately and inc_pending=0.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared helpers for the fractional baud generator: bit-width and
// default phase-increment calculation, evaluated at elaboration time.
package baud_pkg;

  function automatic int clog2(input longint unsigned v);
    int r;
    longint unsigned x;
    r = 0;
    x = v - 64'd1;
    while (x > 64'd0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // round(baud*oversample*2^acc_w / clk_freq), saturated to the accumulator range
  function automatic longint unsigned calc_def_inc(input longint unsigned clk_freq,
                                                   input longint unsigned baud,
                                                   input longint unsigned oversample,
                                                   input int acc_w);
    longint unsigned num;
    longint unsigned quo;
    longint unsigned max_val;
    num     = (baud * oversample) << acc_w;
    quo     = (num + clk_freq / 64'd2) / clk_freq;
    max_val = (64'd1 << acc_w) - 64'd1;
    return (quo > max_val) ? max_val : quo;
  endfunction

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator with a shadowed increment; the carry out of the
// accumulator is the oversample tick.
module phase_acc
  import baud_pkg::*;
#(
  parameter int               ACC_W   = 24,
  parameter logic [ACC_W-1:0] DEF_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             resync,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             inc_load,
  output logic             os_tick,
  output logic             carry,
  output logic             inc_pending
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] inc_reg;
  logic [ACC_W-1:0] shadow_reg;
  logic             pending_reg;
  logic             os_tick_reg;
  logic [ACC_W:0]   sum;
  logic             apply;

  assign sum   = {1'b0, acc_reg} + {1'b0, inc_reg};
  assign carry = enable & ~resync & sum[ACC_W];
  // Swap only at a phase-safe moment: on a carry, while idle, or on resync.
  assign apply = pending_reg & (carry | ~enable | resync);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg     <= '0;
      inc_reg     <= DEF_INC;
      shadow_reg  <= DEF_INC;
      pending_reg <= 1'b0;
      os_tick_reg <= 1'b0;
    end else begin
      if (resync) begin
        acc_reg     <= '0;
        os_tick_reg <= 1'b0;
      end else if (enable) begin
        acc_reg     <= sum[ACC_W-1:0];
        os_tick_reg <= sum[ACC_W];
      end else begin
        os_tick_reg <= 1'b0;
      end

      if (apply) begin
        inc_reg     <= shadow_reg;
        pending_reg <= 1'b0;
      end
      // A load on the apply edge wins the pending flag and holds the new value.
      if (inc_load) begin
        shadow_reg  <= inc_in;
        pending_reg <= 1'b1;
      end
    end
  end

  assign os_tick     = os_tick_reg;
  assign inc_pending = pending_reg;

endmodule

// File: rtl/baud_rate_gen_frac.sv
// Fractional-N baud generator: phase accumulator produces oversample ticks,
// a subcounter divides them down to the bit-rate tick.
module baud_rate_gen_frac
  import baud_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             resync,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             inc_load,
  output logic             os_tick,
  output logic             baud_tick,
  output logic             inc_pending
);

  localparam int               SUB_W    = clog2(64'(OVERSAMPLE));
  localparam logic [ACC_W-1:0] DEF_INC  = ACC_W'(calc_def_inc(64'(CLK_FREQ), 64'(BAUD),
                                                              64'(OVERSAMPLE), ACC_W));
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(OVERSAMPLE / 2);

  logic             carry;
  logic [SUB_W-1:0] sub_reg;
  logic             baud_tick_reg;

  phase_acc #(
    .ACC_W   (ACC_W),
    .DEF_INC (DEF_INC)
  ) u_phase_acc (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .resync      (resync),
    .inc_in      (inc_in),
    .inc_load    (inc_load),
    .os_tick     (os_tick),
    .carry       (carry),
    .inc_pending (inc_pending)
  );

  // Resync parks the subcounter mid-bit so the next baud tick lands at bit centre.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_reg       <= '0;
      baud_tick_reg <= 1'b0;
    end else if (resync) begin
      sub_reg       <= SUB_HALF;
      baud_tick_reg <= 1'b0;
    end else if (carry) begin
      baud_tick_reg <= (sub_reg == SUB_LAST);
      sub_reg       <= (sub_reg == SUB_LAST) ? '0 : sub_reg + 1'b1;
    end else begin
      baud_tick_reg <= 1'b0;
    end
  end

  assign baud_tick = baud_tick_reg;

endmodule

// File: tb/tb_baud_rate_gen_frac.sv
// Directed bench: cycle-table startup check, then hand-sequenced corner cases.
module tb_baud_rate_gen_frac;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       resync = 1'b0;
  logic [7:0] inc_in = '0;
  logic       inc_load = 1'b0;
  logic       os_tick;
  logic       baud_tick;
  logic       inc_pending;

  logic        enable2 = 1'b0;
  logic        resync2 = 1'b0;
  logic [23:0] inc_in2 = '0;
  logic        inc_load2 = 1'b0;
  logic        os_tick2;
  logic        baud_tick2;
  logic        inc_pending2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Small instance: DEF_INC = 16*4*256/1024 = 16
  baud_rate_gen_frac #(
    .CLK_FREQ(1024), .BAUD(16), .OVERSAMPLE(4), .ACC_W(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .resync(resync),
    .inc_in(inc_in), .inc_load(inc_load),
    .os_tick(os_tick), .baud_tick(baud_tick), .inc_pending(inc_pending)
  );

  baud_rate_gen_frac dut_def (
    .clk(clk), .rst(rst), .enable(enable2), .resync(resync2),
    .inc_in(inc_in2), .inc_load(inc_load2),
    .os_tick(os_tick2), .baud_tick(baud_tick2), .inc_pending(inc_pending2)
  );

  typedef struct {
    logic       en;
    logic       rs;
    logic       ld;
    logic [7:0] inc;
    logic       os;
    logic       bd;
    logic       pend;
  } vec_t;

  vec_t vecs[34];

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic rs, input logic ld, input logic [7:0] inc);
    enable   = en;
    resync   = rs;
    inc_load = ld;
    inc_in   = inc;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input bit want_baud, input int maxc, output int n, output int os_seen);
    int c;
    n = -1;
    c = 0;
    os_seen = 0;
    while (n < 0 && c < maxc) begin
      step(1'b1, 1'b0, 1'b0, 8'd0);
      c++;
      if (os_tick) os_seen++;
      if (want_baud ? baud_tick : os_tick) n = c;
    end
  endtask

  initial begin
    int n, n2, os_seen, cnt_os, cnt_bd, cycles;

    // Startup table: load 64 while idle, it applies on the next idle edge,
    // then os_tick every 4th and baud_tick every 16th enabled edge.
    vecs[0] = '{en: 1'b0, rs: 1'b0, ld: 1'b1, inc: 8'd64, os: 1'b0, bd: 1'b0, pend: 1'b1};
    vecs[1] = '{en: 1'b0, rs: 1'b0, ld: 1'b0, inc: 8'd0,  os: 1'b0, bd: 1'b0, pend: 1'b0};
    for (int k = 1; k <= 32; k++) begin
      vecs[k+1].en   = 1'b1;
      vecs[k+1].rs   = 1'b0;
      vecs[k+1].ld   = 1'b0;
      vecs[k+1].inc  = 8'd0;
      vecs[k+1].os   = (k % 4 == 0);
      vecs[k+1].bd   = (k % 16 == 0);
      vecs[k+1].pend = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_os", os_tick, 0);
    check("rst_baud", baud_tick, 0);
    check("rst_pending", inc_pending, 0);
    check("rst_def_pending", inc_pending2, 0);
    #2 rst = 1'b0;

    for (int i = 0; i < 34; i++) begin
      step(vecs[i].en, vecs[i].rs, vecs[i].ld, vecs[i].inc);
      check($sformatf("vec%0d_os", i), os_tick, vecs[i].os);
      check($sformatf("vec%0d_baud", i), baud_tick, vecs[i].bd);
      check($sformatf("vec%0d_pend", i), inc_pending, vecs[i].pend);
      $display("vec %0d: os=%0b baud=%0b pend=%0b", i, os_tick, baud_tick, inc_pending);
    end

    // Resync on an edge that would otherwise carry (acc=192 after 7 steps)
    repeat (7) step(1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 8'd0);
    check("resync_os_blocked", os_tick, 0);
    check("resync_baud_blocked", baud_tick, 0);
    run_until(1'b0, 40, n, os_seen);
    check("resync_first_os", n, 4);
    run_until(1'b1, 40, n2, os_seen);
    check("resync_first_baud_total", n + n2, 8);
    $display("resync: os after %0d, baud after %0d", n, n + n2);

    // Mid-interval load of 128: pending until the next carry
    step(1'b1, 1'b0, 1'b0, 8'd0);
    check("ld128_pre_pend", inc_pending, 0);
    step(1'b1, 1'b0, 1'b1, 8'd128);
    check("ld128_pend_a", inc_pending, 1);
    check("ld128_os_a", os_tick, 0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    check("ld128_pend_b", inc_pending, 1);
    check("ld128_os_b", os_tick, 0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    check("ld128_swap_os", os_tick, 1);
    check("ld128_swap_pend", inc_pending, 0);
    run_until(1'b0, 20, n, os_seen);
    check("ld128_os_period1", n, 2);
    run_until(1'b0, 20, n, os_seen);
    check("ld128_os_period2", n, 2);
    run_until(1'b1, 20, n, os_seen);
    check("ld128_first_baud", n, 2);
    run_until(1'b1, 40, n, os_seen);
    check("ld128_baud_period", n, 8);
    check("ld128_os_per_baud", os_seen, 4);
    $display("inc128: baud period %0d, os per baud %0d", n, os_seen);

    // Enable gap of 5 cycles: next tick shifts from 2 to 7 edges after the baud
    step(1'b1, 1'b0, 1'b0, 8'd0);
    check("gap_pre_os", os_tick, 0);
    cnt_os = 0;
    cnt_bd = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'd0);
      cnt_os += int'(os_tick);
      cnt_bd += int'(baud_tick);
    end
    check("gap_no_os", cnt_os, 0);
    check("gap_no_baud", cnt_bd, 0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    check("gap_resume_os", os_tick, 1);
    check("gap_resume_baud", baud_tick, 0);
    $display("gap: resume os=%0b", os_tick);

    // Zero increment
    step(1'b0, 1'b0, 1'b1, 8'd0);
    check("zero_ld_pend", inc_pending, 1);
    step(1'b0, 1'b0, 1'b0, 8'd0);
    check("zero_applied_pend", inc_pending, 0);
    cnt_os = 0;
    cnt_bd = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'd0);
      cnt_os += int'(os_tick);
      cnt_bd += int'(baud_tick);
    end
    check("zero_os_count", cnt_os, 0);
    check("zero_baud_count", cnt_bd, 0);
    $display("zero inc: os=%0d baud=%0d over 1000", cnt_os, cnt_bd);

    // Load coinciding with apply: older shadow (64) goes live, 128 stays pending
    step(1'b0, 1'b1, 1'b1, 8'd64);
    check("coin_first_pend", inc_pending, 1);
    check("coin_first_os", os_tick, 0);
    step(1'b0, 1'b0, 1'b1, 8'd128);
    check("coin_second_pend", inc_pending, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'd0);
      check($sformatf("coin_run%0d_os", i), os_tick, 0);
      check($sformatf("coin_run%0d_pend", i), inc_pending, 1);
    end
    step(1'b1, 1'b0, 1'b0, 8'd0);
    check("coin_carry_os", os_tick, 1);
    check("coin_carry_pend", inc_pending, 0);
    check("coin_carry_baud", baud_tick, 0);
    run_until(1'b0, 20, n, os_seen);
    check("coin_next_os", n, 2);
    check("coin_next_baud", baud_tick, 1);
    $display("coincide: next os after %0d, baud=%0b", n, baud_tick);

    // Asynchronous reset while a load is pending and os_tick is high
    step(1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b1, 8'd200);
    check("arst_pre_os", os_tick, 1);
    check("arst_pre_pend", inc_pending, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_os", os_tick, 0);
    check("arst_baud", baud_tick, 0);
    check("arst_pend", inc_pending, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    run_until(1'b0, 40, n, os_seen);
    check("arst_def_os", n, 16);
    run_until(1'b1, 100, n, os_seen);
    check("arst_def_baud", n, 48);
    $display("after reset: default os period 16, baud after %0d more", n);

    // Default parameters: 100 baud ticks ~ 43403 cycles, +-0.1%
    enable2 = 1'b1;
    cnt_bd = 0;
    cycles = 0;
    while (cnt_bd < 100 && cycles < 50000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (baud_tick2) cnt_bd++;
    end
    enable2 = 1'b0;
    check("def_baud_count", cnt_bd, 100);
    if (cycles < 43360 || cycles > 43446) begin
      compared++;
      mismatched++;
      $display("FAIL def_rate: got %0d cycles required 43360..43446", cycles);
    end else begin
      compared++;
    end
    $display("default params: 100 baud ticks in %0d cycles", cycles);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
